// File: rtl/hazard_controller_if.sv
// Hazard-controller bundle between the decode-side pipeline logic (master) and the controller (slave).
interface hazard_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       Rs1_D;
    logic [4:0]       Rs2_D;
    logic [4:0]       Rs1_E;
    logic [4:0]       Rs2_E;
    logic [4:0]       Rd_E;
    logic [1:0]       ResultSrc_E;
    logic [4:0]       Rd_M;
    logic             RegWrite_M;
    logic [4:0]       Rd_W;
    logic             RegWrite_W;
    logic             PCSrc_E;
    logic             Stall_F;
    logic             Stall_D;
    logic             Flush_D;
    logic             Flush_E;
    logic [1:0]       ForwardA_E;
    logic [1:0]       ForwardB_E;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E,
               Rd_M, RegWrite_M, Rd_W, RegWrite_W, PCSrc_E,
        input  Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_E, ForwardB_E,
               StallCnt, FlushCnt
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E,
               Rd_M, RegWrite_M, Rd_W, RegWrite_W, PCSrc_E,
        output Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_E, ForwardB_E,
               StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_controller.sv
// EX forwarding, load-use stall sequencing and branch flush for the 5-stage core.
// Optional HAZARD_PERF_EN builds the stall/flush performance counters; otherwise they read 0.
module hazard_controller #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 32
) (
    input logic                clk,
    input logic                rst,
    hazard_controller_if.slave hz
);
    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } state_t;

    localparam logic [2:0] LP_BUBBLES = 3'(MEM_LAT - 1);

    state_t     r_state;
    logic [2:0] r_bub_cnt;

    logic       w_lu_hit;
    logic       w_stall;
    logic       w_flush_d;
    logic       w_flush_e;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_lu_hit = (hz.ResultSrc_E == 2'b01) && (hz.Rd_E != 5'd0) &&
                      ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));

    // M stage wins over W; x0 is never forwarded
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (rst) begin
            if (hz.RegWrite_M && (hz.Rd_M != 5'd0) && (hz.Rd_M == hz.Rs1_E))
                w_fwd_a = 2'b10;
            else if (hz.RegWrite_W && (hz.Rd_W != 5'd0) && (hz.Rd_W == hz.Rs1_E))
                w_fwd_a = 2'b01;
            if (hz.RegWrite_M && (hz.Rd_M != 5'd0) && (hz.Rd_M == hz.Rs2_E))
                w_fwd_b = 2'b10;
            else if (hz.RegWrite_W && (hz.Rd_W != 5'd0) && (hz.Rd_W == hz.Rs2_E))
                w_fwd_b = 2'b01;
        end
    end

    // A taken branch discards the younger instructions, so it overrides any stall
    always_comb begin
        w_stall   = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (!rst) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (hz.PCSrc_E) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if ((r_state == ST_WAIT) || w_lu_hit) begin
            w_stall   = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_bub_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!hz.PCSrc_E && w_lu_hit && (MEM_LAT > 1)) begin
                        r_bub_cnt <= LP_BUBBLES;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (hz.PCSrc_E) begin
                        r_bub_cnt <= '0;
                        r_state   <= ST_RUN;
                    end else begin
                        r_bub_cnt <= r_bub_cnt - 3'd1;
                        if (r_bub_cnt == 3'd1)
                            r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign hz.Stall_F    = w_stall;
    assign hz.Stall_D    = w_stall;
    assign hz.Flush_D    = w_flush_d;
    assign hz.Flush_E    = w_flush_e;
    assign hz.ForwardA_E = w_fwd_a;
    assign hz.ForwardB_E = w_fwd_b;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_d)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign hz.StallCnt = r_stall_cnt;
    assign hz.FlushCnt = r_flush_cnt;
`else
    assign hz.StallCnt = {CNT_W{1'b0}};
    assign hz.FlushCnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller with MEM_LAT = 1, 3 and 4 instances on shared stimulus.
module tb_hazard_controller;
    localparam logic [7:0] C_IDLE  = 8'b0000_0000;
    localparam logic [7:0] C_FLUSH = 8'b0011_0000;
    localparam logic [7:0] C_STALL = 8'b1101_0000;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] rsrc_e;
    logic       rw_m, rw_w, pcsrc;

    logic [7:0]  o_ctl [3];
    logic [31:0] o_sc  [3];
    logic [31:0] o_fc  [3];

    typedef struct {
        string       tag;
        int          inst;
        bit          is_cnt;
        logic [7:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
    } sb_t;

    sb_t sb[$];
    int  n_pass  = 0;
    int  n_total = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        hazard_controller_if #(.CNT_W(32)) hz ();

        assign hz.Rs1_D       = rs1_d;
        assign hz.Rs2_D       = rs2_d;
        assign hz.Rs1_E       = rs1_e;
        assign hz.Rs2_E       = rs2_e;
        assign hz.Rd_E        = rd_e;
        assign hz.ResultSrc_E = rsrc_e;
        assign hz.Rd_M        = rd_m;
        assign hz.RegWrite_M  = rw_m;
        assign hz.Rd_W        = rd_w;
        assign hz.RegWrite_W  = rw_w;
        assign hz.PCSrc_E     = pcsrc;

        assign o_ctl[g] = {hz.Stall_F, hz.Stall_D, hz.Flush_D, hz.Flush_E,
                           hz.ForwardA_E, hz.ForwardB_E};
        assign o_sc[g]  = hz.StallCnt;
        assign o_fc[g]  = hz.FlushCnt;

        hazard_controller #(.MEM_LAT(LAT), .CNT_W(32)) u_dut (
            .clk (clk),
            .rst (rst),
            .hz  (hz)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cv(input int x);
`ifdef HAZARD_PERF_EN
        return 32'(x);
`else
        return (x == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic exp3(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2);
        sb.push_back('{tag, 0, 1'b0, c0, 32'd0, 32'd0});
        sb.push_back('{tag, 1, 1'b0, c1, 32'd0, 32'd0});
        sb.push_back('{tag, 2, 1'b0, c2, 32'd0, 32'd0});
    endtask

    task automatic expc(input string tag, input int s0, input int s1, input int s2,
                        input int f0, input int f1, input int f2);
        sb.push_back('{tag, 0, 1'b1, 8'd0, cv(s0), cv(f0)});
        sb.push_back('{tag, 1, 1'b1, 8'd0, cv(s1), cv(f1)});
        sb.push_back('{tag, 2, 1'b1, 8'd0, cv(s2), cv(f2)});
    endtask

    task automatic check_all();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.is_cnt) begin
                n_total++;
                assert (o_ctl[e.inst] === e.ctl) n_pass++;
                else $error("FAIL %s inst%0d ctl observed=%b expected=%b",
                            e.tag, e.inst, o_ctl[e.inst], e.ctl);
            end else begin
                n_total++;
                assert (o_sc[e.inst] === e.sc) n_pass++;
                else $error("FAIL %s inst%0d StallCnt observed=%0d expected=%0d",
                            e.tag, e.inst, o_sc[e.inst], e.sc);
                n_total++;
                assert (o_fc[e.inst] === e.fc) n_pass++;
                else $error("FAIL %s inst%0d FlushCnt observed=%0d expected=%0d",
                            e.tag, e.inst, o_fc[e.inst], e.fc);
            end
        end
    endtask

    task automatic clear_in();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0;
        rsrc_e = 2'b00; rd_m = 5'd0; rw_m = 1'b0; rd_w = 5'd0; rw_w = 1'b0; pcsrc = 1'b0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        #1 rst = 1'b0;

        // reset held for three cycles with busy inputs
        rs1_e = 5'd5; rd_m = 5'd5; rw_m = 1'b1; rsrc_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pcsrc = 1'(i);
            exp3("reset", C_FLUSH, C_FLUSH, C_FLUSH);
            expc("reset_cnt", 0, 0, 0, 0, 0, 0);
            #1 check_all();
        end

        // forwarding priority
        @(negedge clk);
        rst = 1'b1;
        clear_in();
        rs1_e = 5'd5; rd_m = 5'd5; rw_m = 1'b1; rd_w = 5'd5; rw_w = 1'b1;
        exp3("fwd_m_prio", 8'b0000_1000, 8'b0000_1000, 8'b0000_1000);
        #1 check_all();

        @(negedge clk);
        rw_m = 1'b0;
        exp3("fwd_w", 8'b0000_0100, 8'b0000_0100, 8'b0000_0100);
        #1 check_all();

        @(negedge clk);
        rs1_e = 5'd0; rd_m = 5'd0; rw_m = 1'b1; rd_w = 5'd0;
        exp3("fwd_x0", C_IDLE, C_IDLE, C_IDLE);
        #1 check_all();

        @(negedge clk);
        rs1_e = 5'd3; rs2_e = 5'd9; rd_m = 5'd9; rw_m = 1'b1; rd_w = 5'd3; rw_w = 1'b1;
        exp3("fwd_ab", 8'b0000_0110, 8'b0000_0110, 8'b0000_0110);
        #1 check_all();

        // load-use via rs2: one-cycle hazard pulse, bubbles per MEM_LAT
        @(negedge clk);
        clear_in();
        rsrc_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
        exp3("lu_0", C_STALL, C_STALL, C_STALL);
        expc("lu_0_cnt", 0, 0, 0, 0, 0, 0);
        #1 check_all();

        @(negedge clk);
        clear_in();
        exp3("lu_1", C_IDLE, C_STALL, C_STALL);
        expc("lu_1_cnt", 1, 1, 1, 0, 0, 0);
        #1 check_all();

        @(negedge clk);
        exp3("lu_2", C_IDLE, C_STALL, C_STALL);
        expc("lu_2_cnt", 1, 2, 2, 0, 0, 0);
        #1 check_all();

        @(negedge clk);
        exp3("lu_3", C_IDLE, C_IDLE, C_STALL);
        expc("lu_3_cnt", 1, 3, 3, 0, 0, 0);
        #1 check_all();

        @(negedge clk);
        exp3("lu_4", C_IDLE, C_IDLE, C_IDLE);
        expc("lu_4_cnt", 1, 3, 4, 0, 0, 0);
        #1 check_all();

        // branch together with load-use: flush wins
        @(negedge clk);
        pcsrc = 1'b1; rsrc_e = 2'b01; rd_e = 5'd7; rs1_d = 5'd7;
        exp3("br_lu", C_FLUSH, C_FLUSH, C_FLUSH);
        #1 check_all();

        @(negedge clk);
        clear_in();
        exp3("br_after", C_IDLE, C_IDLE, C_IDLE);
        expc("br_cnt", 1, 3, 4, 1, 1, 1);
        #1 check_all();

        // no hazard on x0 destination or non-load result sources
        @(negedge clk);
        rsrc_e = 2'b01; rd_e = 5'd0;
        exp3("lu_x0", C_IDLE, C_IDLE, C_IDLE);
        #1 check_all();

        @(negedge clk);
        rsrc_e = 2'b00; rd_e = 5'd7; rs1_d = 5'd7;
        exp3("alu_src", C_IDLE, C_IDLE, C_IDLE);
        #1 check_all();

        @(negedge clk);
        rsrc_e = 2'b10;
        exp3("pc4_src", C_IDLE, C_IDLE, C_IDLE);
        expc("nohaz_cnt", 1, 3, 4, 1, 1, 1);
        #1 check_all();

        // branch arriving while a bubble sequence is in progress
        @(negedge clk);
        clear_in();
        rsrc_e = 2'b01; rd_e = 5'd12; rs1_d = 5'd12;
        exp3("wbr_0", C_STALL, C_STALL, C_STALL);
        #1 check_all();

        @(negedge clk);
        clear_in();
        pcsrc = 1'b1;
        exp3("wbr_1", C_FLUSH, C_FLUSH, C_FLUSH);
        #1 check_all();

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            clear_in();
            exp3("wbr_idle", C_IDLE, C_IDLE, C_IDLE);
            #1 check_all();
        end

        // reset during the second stall cycle
        @(negedge clk);
        rsrc_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
        exp3("rw_0", C_STALL, C_STALL, C_STALL);
        #1 check_all();

        @(negedge clk);
        clear_in();
        exp3("rw_1", C_IDLE, C_STALL, C_STALL);
        #1 check_all();
        #1 rst = 1'b0;
        exp3("rw_rst", C_FLUSH, C_FLUSH, C_FLUSH);
        expc("rw_rst_cnt", 0, 0, 0, 0, 0, 0);
        #1 check_all();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b1;
            exp3("rw_post", C_IDLE, C_IDLE, C_IDLE);
            expc("rw_post_cnt", 0, 0, 0, 0, 0, 0);
            #1 check_all();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
